// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// slave = arbiter view, master = requester/memory-side view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_stall;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;

    logic [DATA_W-1:0] rd_data;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_stall,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack,
        output rd_data,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_stall,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack,
        input  rd_data,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port data memory between the
// CPU data port (m0) and the loader port (m1); one transaction in flight at most.
module dmem_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input logic          Clock,
    input logic          Reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic              win;
    logic              win_we;

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        if (bus.m0_req && bus.m1_req) begin
            win = ~last_grant_q;
        end else begin
            win = bus.m1_req;
        end
        win_we = win ? bus.m1_we : bus.m0_we;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd_data_d    = rd_data_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant_d      = win;
                    last_grant_d = win;
                    we_d         = win_we;
                    mem_addr_d   = win ? bus.m1_addr  : bus.m0_addr;
                    mem_wdata_d  = win ? bus.m1_wdata : bus.m0_wdata;
                    // Strobes are registered so they are high exactly during ISSUE.
                    mem_read_d   = ~win_we;
                    mem_write_d  = win_we;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rd_data_d = we_q ? '0 : bus.mem_rdata;
                    m0_ack_d  = ~grant_q;
                    m1_ack_d  = grant_q;
                    state_d   = ACK;
                end
            end
            ACK: begin
                // Requests are deliberately not sampled here so a held req is not re-issued.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_data_q    <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_data_q    <= rd_data_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.m0_ack    = m0_ack_q;
    assign bus.m1_ack    = m1_ack_q;
    // Combinational so the PC/reg-file unfreeze in the very ack cycle.
    assign bus.m0_stall  = bus.m0_req & ~m0_ack_q;
endmodule
